// File: rtl/uart_flit_assembler_if.sv
// uart_flit_assembler_if: UART byte input plus flit valid/ready output,
// with the status pulses of the assembler.
interface uart_flit_assembler_if;
  logic [7:0]  UartData_i;
  logic        UartValid_i;
  logic [31:0] Data_o;
  logic        Valid_o;
  logic        Ready_i;
  logic        Busy_o;
  logic        SeqErr_o;
  logic        Overflow_o;

  modport master (
    output UartData_i, UartValid_i, Ready_i,
    input  Data_o, Valid_o, Busy_o, SeqErr_o, Overflow_o
  );

  modport slave (
    input  UartData_i, UartValid_i, Ready_i,
    output Data_o, Valid_o, Busy_o, SeqErr_o, Overflow_o
  );
endinterface

// File: rtl/uart_flit_assembler.sv
// uart_flit_assembler: rebuilds 32-bit NoC flits from tagged UART bytes.
// Optional inter-byte timeout is enabled by defining UART_FLIT_TIMEOUT_EN.
module uart_flit_assembler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic                  clk,
  input logic                  rstn,
  uart_flit_assembler_if.slave bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    WID, WAD, WHH, WHL, WLH, WLL, WEH, WEL
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    addr_hi_q, addr_hi_d;
  logic [12:0]   d_hi_q, d_hi_d;
  logic [3:0]    e_hi_q, e_hi_d;
  logic          seq_err_q, seq_err_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]  tag;
  logic [4:0]  pl;
  logic        not_empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        flit_vld;
  logic [31:0] flit;
  logic        tmo_fire;

  assign tag       = bus.UartData_i[7:5];
  assign pl        = bus.UartData_i[4:0];
  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign pop       = not_empty & bus.Ready_i;
  assign push      = flit_vld & (~full | pop);

  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    d_hi_d    = d_hi_q;
    e_hi_d    = e_hi_q;
    seq_err_d = 1'b0;
    ovf_d     = 1'b0;
    flit_vld  = 1'b0;
    flit      = '0;
    if (bus.UartValid_i) begin
      if (tag == state_q) begin
        state_d = state_e'(state_q + 3'd1);
        // d_hi holds d[16:4]; low nibbles arrive with the flit-completing byte
        unique case (state_q)
          WID: addr_hi_d = pl;
          WAD: begin
            flit_vld = 1'b1;
            flit     = {22'b0, addr_hi_q, pl};
          end
          WHH: d_hi_d[12:8] = pl;
          WHL: d_hi_d[7:4]  = pl[3:0];
          WLH: d_hi_d[3:0]  = pl[3:0];
          WLL: begin
            flit_vld = 1'b1;
            flit     = {2'b01, 13'b0, d_hi_q, pl[3:0]};
          end
          WEH: e_hi_d = pl[3:0];
          WEL: begin
            flit_vld = 1'b1;
            flit     = {2'b11, 22'b0, e_hi_q, pl[3:0]};
          end
        endcase
        if (flit_vld && full && !pop) begin
          ovf_d   = 1'b1;
          state_d = WID;
        end
      end else begin
        seq_err_d = 1'b1;
        if (tag == 3'd0) begin
          addr_hi_d = pl;
          state_d   = WAD;
        end else begin
          state_d = WID;
        end
      end
    end else if (tmo_fire) begin
      seq_err_d = 1'b1;
      state_d   = WID;
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = flit;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= WID;
      addr_hi_q <= '0;
      d_hi_q    <= '0;
      e_hi_q    <= '0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      d_hi_q    <= d_hi_d;
      e_hi_q    <= e_hi_d;
      seq_err_q <= seq_err_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef UART_FLIT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d    = tmo_q;
    tmo_fire = 1'b0;
    if (bus.UartValid_i || state_q == WID) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_fire = 1'b1;
      tmo_d    = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // output gated so an empty FIFO never shows stale or unreset storage
  assign bus.Data_o     = not_empty ? mem_q[rd_q] : '0;
  assign bus.Valid_o    = not_empty;
  assign bus.Busy_o     = (state_q != WID);
  assign bus.SeqErr_o   = seq_err_q;
  assign bus.Overflow_o = ovf_q;
endmodule
